// File: rtl/l1i_cache.sv
// Direct-mapped, one-word-per-line instruction cache with combinational hits,
// a four-state miss sequencer toward the memory controller, and flash invalidate.
module l1i_cache #(
  parameter int unsigned LINES = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        invalidate,
  output logic [31:0] cpu_data,
  output logic        cpu_ready,
  output logic [31:0] l1i_address,
  output logic        l1i_mem_read,
  input  logic [31:0] mem_data,
  input  logic        stall_l1i,
  output logic [15:0] miss_count
);

  localparam int unsigned IDX  = $clog2(LINES);
  localparam int unsigned TAGW = 30 - IDX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LINES-1:0]  r_valid;
  logic [TAGW-1:0]   r_tag [LINES];
  logic [31:0]       r_data [LINES];
  logic [29:0]       r_miss_word;
  logic [31:0]       r_fill_data;
  logic [15:0]       r_miss_count;

  logic [IDX-1:0]    w_idx;
  logic [TAGW-1:0]   w_tag;
  logic [IDX-1:0]    w_miss_idx;
  logic [TAGW-1:0]   w_miss_tag;
  logic              w_latch_miss;
  logic              w_fill;
  logic              w_unused;

  assign w_idx       = cpu_address[IDX+1:2];
  assign w_tag       = cpu_address[31:IDX+2];
  assign w_miss_idx  = r_miss_word[IDX-1:0];
  assign w_miss_tag  = r_miss_word[29:IDX];
  assign w_fill      = (r_state == S_WAIT);
  assign w_unused    = ^cpu_address[1:0];
  assign l1i_address = {r_miss_word, 2'b00};
  assign miss_count  = r_miss_count;

  // Lookup, response muxing and next-state; cpu_data is forced to 0 when not ready.
  always_comb begin
    w_state_nxt  = r_state;
    w_latch_miss = 1'b0;
    cpu_ready    = 1'b0;
    cpu_data     = 32'd0;
    l1i_mem_read = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_read) begin
          if (r_valid[w_idx] && (r_tag[w_idx] == w_tag)) begin
            cpu_ready = 1'b1;
            cpu_data  = r_data[w_idx];
          end else begin
            w_latch_miss = 1'b1;
            w_state_nxt  = S_REQ;
          end
        end
      end
      S_REQ: begin
        l1i_mem_read = 1'b1;
        if (!stall_l1i) w_state_nxt = S_WAIT;
      end
      S_WAIT: w_state_nxt = S_RESP;
      S_RESP: begin
        cpu_ready   = 1'b1;
        cpu_data    = r_fill_data;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state; invalidate takes priority over the valid set of a fill.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_miss_word  <= 30'd0;
      r_fill_data  <= 32'd0;
      r_miss_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_miss) r_miss_word <= cpu_address[31:2];
      if (w_fill) begin
        r_fill_data  <= mem_data;
        r_miss_count <= r_miss_count + 16'd1;
      end
      if (invalidate) r_valid <= '0;
      else if (w_fill) r_valid[w_miss_idx] <= 1'b1;
    end
  end

  // Tag/data storage is only meaningful behind a valid bit, so it needs no reset.
  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_l1i_cache.sv
// Directed plus randomized fetch sequences against an address-level model of a
// direct-mapped cache backed by a one-cycle-latency ROM.
module tb_l1i_cache;

  localparam int unsigned LINES = 8;

  logic        clock;
  logic        reset_n;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        invalidate;
  logic [31:0] cpu_data;
  logic        cpu_ready;
  logic [31:0] l1i_address;
  logic        l1i_mem_read;
  logic [31:0] mem_data;
  logic        stall_l1i;
  logic [15:0] miss_count;

  int n_pass;
  int n_total;

  bit          m_valid [LINES];
  logic [29:0] m_word  [LINES];
  logic [31:0] m_data  [LINES];
  int          m_count;

  l1i_cache #(.LINES(LINES)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cpu_address  (cpu_address),
    .cpu_read     (cpu_read),
    .invalidate   (invalidate),
    .cpu_data     (cpu_data),
    .cpu_ready    (cpu_ready),
    .l1i_address  (l1i_address),
    .l1i_mem_read (l1i_mem_read),
    .mem_data     (mem_data),
    .stall_l1i    (stall_l1i),
    .miss_count   (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h4) return 32'h00100093;
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // ROM answers an accepted request on the following cycle; garbage otherwise.
  always @(posedge clock) begin
    if (l1i_mem_read && !stall_l1i) mem_data <= rom(l1i_address);
    else mem_data <= $urandom();
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic model_clear_valid();
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
  endtask

  // inv_mode: 0 none, 1 invalidate in the request cycle, 2 invalidate on the fill edge.
  task automatic fetch(input logic [31:0] addr, input int stall, input int inv_mode);
    logic [29:0] w;
    int          idx;
    bit          hit;
    w   = addr[31:2];
    idx = int'(w % 30'(LINES));
    hit = m_valid[idx] && (m_word[idx] == w);
    @(negedge clock);
    cpu_address = addr;
    cpu_read    = 1'b1;
    stall_l1i   = 1'b0;
    invalidate  = (inv_mode == 1);
    #1;
    if (hit) begin
      check("hit_ready", 32'(cpu_ready), 32'd1);
      check("hit_data", cpu_data, m_data[idx]);
      check("hit_memrd", 32'(l1i_mem_read), 32'd0);
      if (inv_mode == 1) model_clear_valid();
    end else begin
      check("miss_c0_ready", 32'(cpu_ready), 32'd0);
      if (inv_mode == 1) model_clear_valid();
      for (int k = 0; k <= stall; k++) begin
        @(negedge clock);
        invalidate = 1'b0;
        stall_l1i  = (k < stall);
        #1;
        check("req_memrd", 32'(l1i_mem_read), 32'd1);
        check("req_addr", l1i_address, {w, 2'b00});
        check("req_ready", 32'(cpu_ready), 32'd0);
      end
      @(negedge clock);
      stall_l1i  = 1'b0;
      invalidate = (inv_mode == 2);
      #1;
      check("wait_memrd", 32'(l1i_mem_read), 32'd0);
      check("wait_ready", 32'(cpu_ready), 32'd0);
      if (inv_mode == 2) model_clear_valid();
      m_word[idx]  = w;
      m_data[idx]  = rom({w, 2'b00});
      m_valid[idx] = (inv_mode != 2);
      m_count++;
      @(negedge clock);
      invalidate = 1'b0;
      #1;
      check("resp_ready", 32'(cpu_ready), 32'd1);
      check("resp_data", cpu_data, rom({w, 2'b00}));
    end
    @(negedge clock);
    cpu_read   = 1'b0;
    invalidate = 1'b0;
    stall_l1i  = 1'b0;
    #1;
    check("idle_ready", 32'(cpu_ready), 32'd0);
    check("idle_data", cpu_data, 32'd0);
    check("miss_count", 32'(miss_count), 32'(m_count[15:0]));
  endtask

  task automatic pulse_invalidate();
    @(negedge clock);
    invalidate = 1'b1;
    @(negedge clock);
    invalidate = 1'b0;
    model_clear_valid();
  endtask

  // Start a miss, then pull reset asynchronously in the REQ (0) or WAIT (1) cycle.
  task automatic reset_mid_miss(input logic [31:0] addr, input int in_wait);
    @(negedge clock);
    cpu_address = addr;
    cpu_read    = 1'b1;
    @(negedge clock);
    #1;
    check("rst_pre_memrd", 32'(l1i_mem_read), 32'd1);
    if (in_wait != 0) begin
      @(negedge clock);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check("rst_memrd", 32'(l1i_mem_read), 32'd0);
    check("rst_addr", l1i_address, 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_data", cpu_data, 32'd0);
    check("rst_count", 32'(miss_count), 32'd0);
    model_clear_valid();
    m_count  = 0;
    cpu_read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    int          st;
    int          im;
    n_pass      = 0;
    n_total     = 0;
    m_count     = 0;
    model_clear_valid();
    reset_n     = 1'b0;
    cpu_address = 32'd0;
    cpu_read    = 1'b0;
    invalidate  = 1'b0;
    stall_l1i   = 1'b0;
    #1;
    check("reset_ready", 32'(cpu_ready), 32'd0);
    check("reset_data", cpu_data, 32'd0);
    check("reset_memrd", 32'(l1i_mem_read), 32'd0);
    check("reset_addr", l1i_address, 32'd0);
    check("reset_count", 32'(miss_count), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    fetch(32'h04, 0, 0);
    fetch(32'h04, 0, 0);
    fetch(32'h06, 0, 0);
    fetch(32'h24, 0, 0);
    fetch(32'h04, 0, 0);
    fetch(32'h08, 3, 0);
    fetch(32'h08, 0, 0);
    pulse_invalidate();
    fetch(32'h04, 0, 0);
    fetch(32'h04, 0, 1);
    fetch(32'h04, 0, 0);
    fetch(32'h0C, 0, 2);
    fetch(32'h0C, 0, 0);
    fetch(32'h0C, 0, 0);

    reset_mid_miss(32'h10, 1);
    fetch(32'h10, 0, 0);
    fetch(32'h10, 0, 0);
    reset_mid_miss(32'h14, 0);
    fetch(32'h10, 0, 0);

    for (int i = 0; i < 80; i++) begin
      a  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = a | 32'h0000_0100;
      st = int'($urandom_range(0, 2));
      im = int'($urandom_range(0, 11));
      im = (im == 0) ? 1 : ((im == 1) ? 2 : 0);
      fetch(a, st, im);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
